pr_apply_writeback: RTL

- Sits directly downstream of the PageRank apply pipeline (one instance per apply pipeline, 4 per PE).
- Consumes the final (addr, rank, one-hot bank valid) stream and buffers it, because apply has no backpressure.
- Drains the buffer one write per granted cycle into the vertex BRAM write arbiter.
- Counts committed writes per iteration and pulses iter_done once iter_vertex_num ranks have been committed.

---
 rtl/pr_apply_writeback_pkg.sv | 24 ++
 rtl/pr_writeback_fifo.sv | 45 ++++
 rtl/pr_apply_writeback.sv | 122 ++++++++++++
 3 files changed

// File: rtl/pr_apply_writeback_pkg.sv
// Shared types and default widths for the PageRank apply write-back block.
package pr_apply_writeback_pkg;

  localparam int DEF_DST_ID_DWIDTH         = 16;
  localparam int DEF_VERTEX_BRAM_DWIDTH    = 32;
  localparam int DEF_VERTEX_BRAM_AWIDTH    = 12;
  localparam int DEF_VERTEX_BRAM_NUM_WIDTH = 2;
  localparam int DEF_WB_VALID_WIDTH        = 4;
  localparam int DEF_FIFO_AWIDTH           = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } wb_state_e;

  // One buffered write, laid out exactly as the FIFO word (bank, addr, data).
  typedef struct packed {
    logic [DEF_WB_VALID_WIDTH-1:0]     bank;
    logic [DEF_VERTEX_BRAM_AWIDTH-1:0] addr;
    logic [DEF_VERTEX_BRAM_DWIDTH-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/pr_writeback_fifo.sv
// First-word-fall-through FIFO; a push while full is taken when a pop frees a slot in the same cycle.
module pr_writeback_fifo #(
  parameter int WIDTH  = 8,
  parameter int AWIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int DEPTH = 1 << AWIDTH;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AWIDTH:0]  wr_ptr_q, rd_ptr_q;
  logic             push_ok, pop_ok;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AWIDTH] != rd_ptr_q[AWIDTH]) &&
                   (wr_ptr_q[AWIDTH-1:0] == rd_ptr_q[AWIDTH-1:0]);
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);
  assign dout_o  = mem_q[rd_ptr_q[AWIDTH-1:0]];

  // NOTE: storage has no reset; the pointers alone define which words are valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[AWIDTH-1:0]] <= din_i;
  end

  // NOTE: state flops use non-blocking assignments so every reader sees pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + (AWIDTH+1)'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + (AWIDTH+1)'(1);
    end
  end

endmodule

// File: rtl/pr_apply_writeback.sv
// Buffers the apply pipeline's rank stream, drains it into the vertex BRAM arbiter and
// counts committed writes per iteration, pulsing iter_done when the iteration is complete.
module pr_apply_writeback
  import pr_apply_writeback_pkg::*;
#(
  parameter int DST_ID_DWIDTH         = DEF_DST_ID_DWIDTH,
  parameter int VERTEX_BRAM_DWIDTH    = DEF_VERTEX_BRAM_DWIDTH,
  parameter int VERTEX_BRAM_AWIDTH    = DEF_VERTEX_BRAM_AWIDTH,
  parameter int VERTEX_BRAM_NUM_WIDTH = DEF_VERTEX_BRAM_NUM_WIDTH,
  parameter int WB_VALID_WIDTH        = DEF_WB_VALID_WIDTH,
  parameter int FIFO_AWIDTH           = DEF_FIFO_AWIDTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          iter_start,
  input  logic [DST_ID_DWIDTH-1:0]      iter_vertex_num,
  input  logic [DST_ID_DWIDTH-1:0]      wb_dst_addr,
  input  logic [VERTEX_BRAM_DWIDTH-1:0] wb_dst_data,
  input  logic [WB_VALID_WIDTH-1:0]     wb_dst_data_valid,
  output logic                          bram_wr_en,
  output logic [WB_VALID_WIDTH-1:0]     bram_wr_bank,
  output logic [VERTEX_BRAM_AWIDTH-1:0] bram_wr_addr,
  output logic [VERTEX_BRAM_DWIDTH-1:0] bram_wr_data,
  input  logic                          bram_wr_ready,
  output logic [DST_ID_DWIDTH-1:0]      wr_count,
  output logic                          iter_done,
  output logic                          busy,
  output logic                          overflow_err,
  output logic                          stray_err
);

  localparam int EW = WB_VALID_WIDTH + VERTEX_BRAM_AWIDTH + VERTEX_BRAM_DWIDTH;

  logic          push, commit, fifo_full, fifo_empty;
  logic [EW-1:0] fifo_din, fifo_dout;

  wb_state_e                  state_q, state_d;
  logic [DST_ID_DWIDTH-1:0]   target_q, target_d;
  logic [DST_ID_DWIDTH-1:0]   wr_count_q, wr_count_d;
  logic                       ovf_q, ovf_d;
  logic                       stray_q, stray_d;

  // Only a bit-slice of the vertex id addresses the bank; the rest is consumed here on purpose.
  logic unused_addr_bits;
  assign unused_addr_bits = ^wb_dst_addr;

  assign push     = |wb_dst_data_valid;
  assign fifo_din = {wb_dst_data_valid,
                     wb_dst_addr[VERTEX_BRAM_NUM_WIDTH +: VERTEX_BRAM_AWIDTH],
                     wb_dst_data};

  pr_writeback_fifo #(
    .WIDTH  (EW),
    .AWIDTH (FIFO_AWIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .push_i  (push),
    .din_i   (fifo_din),
    .pop_i   (bram_wr_ready),
    .dout_o  (fifo_dout),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bram_wr_en = !fifo_empty;
  assign commit     = bram_wr_en && bram_wr_ready;
  // Mask the head while empty so stale storage never reaches the arbiter.
  assign {bram_wr_bank, bram_wr_addr, bram_wr_data} = fifo_empty ? '0 : fifo_dout;

  // NOTE: every _d takes its current value first, so no branch can leave a latch behind.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    wr_count_d = wr_count_q;
    ovf_d      = ovf_q;
    stray_d    = stray_q;
    unique case (state_q)
      IDLE: begin
        if (iter_start) begin
          state_d    = RUN;
          target_d   = iter_vertex_num;
          wr_count_d = '0;
          ovf_d      = 1'b0;
          stray_d    = 1'b0;
        end
      end
      RUN: begin
        if (commit) wr_count_d = wr_count_q + DST_ID_DWIDTH'(1);
        if ((wr_count_q + DST_ID_DWIDTH'(commit)) == target_q) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (push && fifo_full && !commit) ovf_d = 1'b1;
    // Stray ranks are still buffered and written, only flagged as unexpected.
    if (push && state_q != RUN) stray_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      target_q   <= '0;
      wr_count_q <= '0;
      ovf_q      <= 1'b0;
      stray_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      wr_count_q <= wr_count_d;
      ovf_q      <= ovf_d;
      stray_q    <= stray_d;
    end
  end

  assign wr_count     = wr_count_q;
  assign iter_done    = (state_q == DONE);
  assign busy         = (state_q == RUN);
  assign overflow_err = ovf_q;
  assign stray_err    = stray_q;

endmodule
